// File: rtl/grid_dp_pkg.sv
// Shared types and default direction codes for the grid shortest-path engine.
package grid_dp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_M,
        RD_L,
        CALC,
        WR,
        DONE
    } state_t;

    localparam logic [7:0] CODE_START_DEF = 8'h08;
    localparam logic [7:0] CODE_RIGHT_DEF = 8'h09;
    localparam logic [7:0] CODE_DOWN_DEF  = 8'h0A;

endpackage

// File: rtl/grid_dp_alu.sv
// Predecessor selection and cost accumulation for one grid cell (combinational).
// Optional saturating adder enabled by defining GRID_DP_SAT_ADD_EN.
module grid_dp_alu
    import grid_dp_pkg::*;
#(
    parameter int                   D_WIDTH    = 8,
    parameter logic [D_WIDTH-1:0]   CODE_START = D_WIDTH'(CODE_START_DEF),
    parameter logic [D_WIDTH-1:0]   CODE_RIGHT = D_WIDTH'(CODE_RIGHT_DEF),
    parameter logic [D_WIDTH-1:0]   CODE_DOWN  = D_WIDTH'(CODE_DOWN_DEF)
) (
    input  logic [D_WIDTH-1:0] m,
    input  logic [D_WIDTH-1:0] up,
    input  logic [D_WIDTH-1:0] left,
    input  logic               is_first,
    input  logic               r0,
    input  logic               c0,
    output logic [D_WIDTH-1:0] sum,
    output logic [D_WIDTH-1:0] code,
    output logic               overflow
);

    logic [D_WIDTH-1:0] pred;

    // Ties between left and up resolve towards up (DOWN).
    always_comb begin
        pred = '0;
        code = CODE_START;
        if (is_first) begin
            pred = '0;
            code = CODE_START;
        end else if (r0) begin
            pred = left;
            code = CODE_RIGHT;
        end else if (c0) begin
            pred = up;
            code = CODE_DOWN;
        end else if (left < up) begin
            pred = left;
            code = CODE_RIGHT;
        end else begin
            pred = up;
            code = CODE_DOWN;
        end
    end

`ifdef GRID_DP_SAT_ADD_EN
    logic [D_WIDTH:0] wide;
    assign wide     = {1'b0, m} + {1'b0, pred};
    assign overflow = wide[D_WIDTH];
    assign sum      = overflow ? {D_WIDTH{1'b1}} : wide[D_WIDTH-1:0];
`else
    assign sum      = m + pred;
    assign overflow = 1'b0;
`endif

endmodule

// File: rtl/grid_path_dp.sv
// Row-major min-cost DP over a ROWS x COLS grid in RAM M, writing costs to L and
// direction codes to P. Saturating sums when GRID_DP_SAT_ADD_EN is defined.
module grid_path_dp
    import grid_dp_pkg::*;
#(
    parameter int                   D_WIDTH    = 8,
    parameter int                   A_WIDTH    = 13,
    parameter int                   COLS       = 4,
    parameter int                   ROWS       = 2048,
    parameter logic [D_WIDTH-1:0]   CODE_START = D_WIDTH'(CODE_START_DEF),
    parameter logic [D_WIDTH-1:0]   CODE_RIGHT = D_WIDTH'(CODE_RIGHT_DEF),
    parameter logic [D_WIDTH-1:0]   CODE_DOWN  = D_WIDTH'(CODE_DOWN_DEF)
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Go,
    input  logic [D_WIDTH-1:0] M_In,
    input  logic [D_WIDTH-1:0] L_In,
    output logic               M_En,
    output logic [A_WIDTH-1:0] M_Addr,
    output logic               L_En,
    output logic               L_Rw,
    output logic [A_WIDTH-1:0] L_Addr,
    output logic [D_WIDTH-1:0] L_Out,
    output logic               P_En,
    output logic               P_Rw,
    output logic [A_WIDTH-1:0] P_Addr,
    output logic [D_WIDTH-1:0] P_Out,
    output logic               Busy,
    output logic               Done,
    output logic               Sat
);

    localparam logic [A_WIDTH-1:0] LAST_R = A_WIDTH'(ROWS - 1);
    localparam logic [A_WIDTH-1:0] LAST_C = A_WIDTH'(COLS - 1);
    localparam logic [A_WIDTH-1:0] COLS_A = A_WIDTH'(COLS);
    localparam logic [A_WIDTH-1:0] ONE_A  = A_WIDTH'(1);

    state_t             state_reg, state_next;
    logic [A_WIDTH-1:0] r_reg, r_next, c_reg, c_next, a_reg, a_next;
    logic [D_WIDTH-1:0] m_reg, up_reg;
    logic               sat_reg, sat_next;

    logic               m_en_reg, m_en_next;
    logic [A_WIDTH-1:0] m_addr_reg, m_addr_next;
    logic               l_en_reg, l_en_next, l_rw_reg, l_rw_next;
    logic [A_WIDTH-1:0] l_addr_reg, l_addr_next;
    logic [D_WIDTH-1:0] l_out_reg, l_out_next;
    logic               p_en_reg, p_en_next, p_rw_reg, p_rw_next;
    logic [A_WIDTH-1:0] p_addr_reg, p_addr_next;
    logic [D_WIDTH-1:0] p_out_reg, p_out_next;
    logic               busy_reg, busy_next, done_reg, done_next;

    logic [D_WIDTH-1:0] alu_sum, alu_code;
    logic               alu_ovf;

    // The left neighbour arrives on L_In during CALC and is consumed directly.
    grid_dp_alu #(
        .D_WIDTH    (D_WIDTH),
        .CODE_START (CODE_START),
        .CODE_RIGHT (CODE_RIGHT),
        .CODE_DOWN  (CODE_DOWN)
    ) u_alu (
        .m        (m_reg),
        .up       (up_reg),
        .left     (L_In),
        .is_first ((r_reg == '0) && (c_reg == '0)),
        .r0       (r_reg == '0),
        .c0       (c_reg == '0),
        .sum      (alu_sum),
        .code     (alu_code),
        .overflow (alu_ovf)
    );

    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        c_next     = c_reg;
        a_next     = a_reg;
        sat_next   = sat_reg;
        case (state_reg)
            IDLE: begin
                if (Go) begin
                    state_next = RD_M;
                    r_next     = '0;
                    c_next     = '0;
                    a_next     = '0;
                    sat_next   = 1'b0;
                end
            end
            RD_M: state_next = RD_L;
            RD_L: state_next = CALC;
            CALC: begin
                state_next = WR;
                if (alu_ovf) sat_next = 1'b1;
            end
            WR: begin
                a_next = a_reg + ONE_A;
                if (c_reg == LAST_C) begin
                    c_next = '0;
                    r_next = r_reg + ONE_A;
                end else begin
                    c_next = c_reg + ONE_A;
                end
                state_next = ((r_reg == LAST_R) && (c_reg == LAST_C)) ? DONE : RD_M;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so every port is a flop.
    always_comb begin
        m_en_next   = 1'b0;
        m_addr_next = m_addr_reg;
        l_en_next   = 1'b0;
        l_rw_next   = 1'b0;
        l_addr_next = l_addr_reg;
        l_out_next  = l_out_reg;
        p_en_next   = 1'b0;
        p_rw_next   = 1'b0;
        p_addr_next = p_addr_reg;
        p_out_next  = p_out_reg;
        busy_next   = (state_next != IDLE);
        done_next   = (state_next == DONE);
        case (state_next)
            RD_M: begin
                m_en_next   = 1'b1;
                m_addr_next = a_next;
                if (r_next != '0) begin
                    l_en_next   = 1'b1;
                    l_addr_next = a_next - COLS_A;
                end
            end
            RD_L: begin
                if (c_next != '0) begin
                    l_en_next   = 1'b1;
                    l_addr_next = a_next - ONE_A;
                end
            end
            WR: begin
                l_en_next   = 1'b1;
                l_rw_next   = 1'b1;
                l_addr_next = a_next;
                l_out_next  = alu_sum;
                p_en_next   = 1'b1;
                p_rw_next   = 1'b1;
                p_addr_next = a_next;
                p_out_next  = alu_code;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg  <= IDLE;
            r_reg      <= '0;
            c_reg      <= '0;
            a_reg      <= '0;
            m_reg      <= '0;
            up_reg     <= '0;
            sat_reg    <= 1'b0;
            m_en_reg   <= 1'b0;
            m_addr_reg <= '0;
            l_en_reg   <= 1'b0;
            l_rw_reg   <= 1'b0;
            l_addr_reg <= '0;
            l_out_reg  <= '0;
            p_en_reg   <= 1'b0;
            p_rw_reg   <= 1'b0;
            p_addr_reg <= '0;
            p_out_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            r_reg      <= r_next;
            c_reg      <= c_next;
            a_reg      <= a_next;
            sat_reg    <= sat_next;
            m_en_reg   <= m_en_next;
            m_addr_reg <= m_addr_next;
            l_en_reg   <= l_en_next;
            l_rw_reg   <= l_rw_next;
            l_addr_reg <= l_addr_next;
            l_out_reg  <= l_out_next;
            p_en_reg   <= p_en_next;
            p_rw_reg   <= p_rw_next;
            p_addr_reg <= p_addr_next;
            p_out_reg  <= p_out_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            if (state_reg == RD_L) begin
                m_reg <= M_In;
                if (r_reg != '0) up_reg <= L_In;
            end
        end
    end

    assign M_En   = m_en_reg;
    assign M_Addr = m_addr_reg;
    assign L_En   = l_en_reg;
    assign L_Rw   = l_rw_reg;
    assign L_Addr = l_addr_reg;
    assign L_Out  = l_out_reg;
    assign P_En   = p_en_reg;
    assign P_Rw   = p_rw_reg;
    assign P_Addr = p_addr_reg;
    assign P_Out  = p_out_reg;
    assign Busy   = busy_reg;
    assign Done   = done_reg;
    assign Sat    = sat_reg;

endmodule

// File: tb/tb_grid_path_dp.sv
// Scoreboard bench for grid_path_dp on a 2x3 grid with external RAM models.
module tb_grid_path_dp;

    localparam int NR    = 2;
    localparam int NC    = 3;
    localparam int NCELL = NR * NC;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Go = 1'b0;
    logic [7:0]  M_In = '0;
    logic [7:0]  L_In = '0;
    logic        M_En, L_En, L_Rw, P_En, P_Rw, Busy, Done, Sat;
    logic [12:0] M_Addr, L_Addr, P_Addr;
    logic [7:0]  L_Out, P_Out;

    grid_path_dp #(.ROWS(NR), .COLS(NC)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Go(Go), .M_In(M_In), .L_In(L_In),
        .M_En(M_En), .M_Addr(M_Addr), .L_En(L_En), .L_Rw(L_Rw), .L_Addr(L_Addr),
        .L_Out(L_Out), .P_En(P_En), .P_Rw(P_Rw), .P_Addr(P_Addr), .P_Out(P_Out),
        .Busy(Busy), .Done(Done), .Sat(Sat)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem_m [0:63];
    logic [7:0] mem_l [0:63];
    logic [7:0] mem_p [0:63];

    always @(posedge Clk) begin
        if (M_En) M_In <= mem_m[M_Addr[5:0]];
        if (L_En) begin
            if (L_Rw) mem_l[L_Addr[5:0]] <= L_Out;
            else      L_In <= mem_l[L_Addr[5:0]];
        end
        if (P_En && P_Rw) mem_p[P_Addr[5:0]] <= P_Out;
    end

    typedef struct { int addr; logic [7:0] l; logic [7:0] p; } wr_t;
    typedef struct { int cyc; bit sat; } dn_t;
    wr_t exp_q [$];
    dn_t done_q [$];

    int cyc = 0;
    int go_cyc = -100;
    bit pattern_on = 1'b0;
    int n_checks = 0;
    int n_pass = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Scoreboard for L/P writes and Done pulses.
    always @(negedge Clk) begin
        if (Rst_n && L_En && L_Rw) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1'b0, {51'd0, L_Addr}, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write", (L_Addr == 13'(e.addr)) && (P_Addr == 13'(e.addr)) && P_En && P_Rw
                             && (L_Out == e.l) && (P_Out == e.p),
                    {P_En, P_Rw, L_Addr, P_Addr, L_Out, P_Out},
                    {1'b1, 1'b1, 13'(e.addr), 13'(e.addr), e.l, e.p});
                $display("write addr=%0d L=%0d P=%h", L_Addr, L_Out, P_Out);
            end
        end
        if (Rst_n && Done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1'b0, 64'(cyc), 64'd0);
            end else begin
                dn_t d;
                d = done_q.pop_front();
                chk("done_cycle_sat", (cyc == d.cyc) && (Sat == d.sat), {31'd0, Sat, 32'(cyc)},
                    {31'd0, d.sat, 32'(d.cyc)});
                $display("done at offset %0d sat=%0d", cyc - go_cyc, Sat);
            end
        end
    end

    // Per-cycle access protocol rules.
    always @(negedge Clk) begin
        if (Rst_n) begin
            chk("protocol", !(M_En && L_Rw) && (P_En == (L_En && L_Rw)) && (P_Rw == P_En) && (!L_Rw || L_En),
                {59'd0, M_En, L_En, L_Rw, P_En, P_Rw},
                {59'd0, M_En, L_En, L_En && L_Rw, L_En && L_Rw, L_En && L_Rw});
        end
    end

    // Expected enable/address trace derived from the 4-cycle-per-cell schedule.
    always @(negedge Clk) begin
        int off, k, ph, r, c, ema, ela;
        bit eb, ed, em, elr, elw, ep;
        if (Rst_n && pattern_on) begin
            off = cyc - go_cyc;
            if (off >= 1 && off <= 4 * NCELL + 2) begin
                k = (off - 1) / 4; ph = (off - 1) % 4; r = k / NC; c = k % NC;
                eb = 0; ed = 0; em = 0; elr = 0; elw = 0; ep = 0; ema = 0; ela = 0;
                if (k < NCELL) begin
                    eb = 1;
                    if (ph == 0) begin
                        em = 1; ema = k;
                        if (r > 0) begin elr = 1; ela = k - NC; end
                    end else if (ph == 1) begin
                        if (c > 0) begin elr = 1; ela = k - 1; end
                    end else if (ph == 3) begin
                        elw = 1; ela = k; ep = 1;
                    end
                end else if (off == 4 * NCELL + 1) begin
                    eb = 1; ed = 1;
                end
                chk("trace",
                    {Busy, Done, M_En, (M_En ? M_Addr : 13'd0), L_En && !L_Rw, L_En && L_Rw,
                     (L_En ? L_Addr : 13'd0), P_En && P_Rw}
                    == {eb, ed, em, 13'(ema), elr, elw, 13'(ela), ep},
                    {34'd0, Busy, Done, M_En, (M_En ? M_Addr : 13'd0), L_En && !L_Rw, L_En && L_Rw,
                     (L_En ? L_Addr : 13'd0), P_En && P_Rw},
                    {34'd0, eb, ed, em, 13'(ema), elr, elw, 13'(ela), ep});
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return {1'b0, M_En, M_Addr, L_En, L_Rw, L_Addr, L_Out, P_En, P_Rw, P_Addr, P_Out, Busy, Done, Sat};
    endfunction

    // Cell k lives in bits [8k+:8] of each vector.
    task automatic run(input logic [47:0] mv, input logic [47:0] lv, input logic [47:0] pv,
                       input bit sat_e, input int pulse_off, input int abort_k);
        int t;
        int nwr;
        for (int k = 0; k < NCELL; k++) mem_m[k] = mv[8*k +: 8];
        nwr = (abort_k >= 0) ? abort_k : NCELL;
        for (int k = 0; k < nwr; k++) exp_q.push_back('{k, lv[8*k +: 8], pv[8*k +: 8]});
        @(negedge Clk);
        Go = 1'b1;
        go_cyc = cyc;
        pattern_on = (abort_k < 0);
        if (abort_k < 0) done_q.push_back('{cyc + 4 * NCELL + 1, sat_e});
        @(negedge Clk);
        Go = 1'b0;
        if (pulse_off > 0) begin
            while (cyc < go_cyc + pulse_off) @(negedge Clk);
            Go = 1'b1;
            @(negedge Clk);
            Go = 1'b0;
        end
        if (abort_k >= 0) begin
            while (cyc < go_cyc + 3 + 4 * abort_k) @(negedge Clk);
            @(posedge Clk);
            #2 Rst_n = 1'b0;
            #1 chk("async_reset_outputs", all_outs() == 64'd0, all_outs(), 64'd0);
            repeat (4) @(negedge Clk);
            chk("reset_hold_outputs", all_outs() == 64'd0, all_outs(), 64'd0);
            Rst_n = 1'b1;
            repeat (4) @(negedge Clk);
        end else begin
            t = 0;
            while (done_q.size() != 0 && t < 200) begin
                @(negedge Clk);
                t++;
            end
            chk("done_timeout", t < 200, 64'(t), 64'd200);
            repeat (4) @(negedge Clk);
        end
        pattern_on = 1'b0;
        chk("writes_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
        repeat (3) @(negedge Clk);
        chk("reset_outputs", all_outs() == 64'd0, all_outs(), 64'd0);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        chk("idle_not_busy", {Busy, Done} == 2'b00, {62'd0, Busy, Done}, 64'd0);

        // M=[1 2 3; 4 1 1] -> L=[1 3 6; 5 4 5], P=[08 09 09; 0A 0A 09]
        run({8'd1, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd5, 8'd4, 8'd5, 8'd6, 8'd3, 8'd1},
            {8'h09, 8'h0A, 8'h0A, 8'h09, 8'h09, 8'h08}, 1'b0, 0, -1);
        // Same grid with a stray Go five cycles into the run.
        run({8'd1, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd5, 8'd4, 8'd5, 8'd6, 8'd3, 8'd1},
            {8'h09, 8'h0A, 8'h0A, 8'h09, 8'h09, 8'h08}, 1'b0, 5, -1);
`ifdef GRID_DP_SAT_ADD_EN
        run({8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd200}, {8'd200, 8'd200, 8'd200, 8'd255, 8'd255, 8'd200},
            {8'h09, 8'h09, 8'h0A, 8'h09, 8'h09, 8'h08}, 1'b1, 0, -1);
`else
        run({8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd200}, {8'd144, 8'd144, 8'd200, 8'd144, 8'd144, 8'd200},
            {8'h0A, 8'h0A, 8'h0A, 8'h09, 8'h09, 8'h08}, 1'b0, 0, -1);
`endif
        // All ones: (1,1) and (1,2) are ties and go DOWN.
        run({8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd3, 8'd2, 8'd1},
            {8'h0A, 8'h0A, 8'h0A, 8'h09, 8'h09, 8'h08}, 1'b0, 0, -1);
        // Abort during WR of cell 3, then a clean rerun.
        run({8'd1, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd5, 8'd4, 8'd5, 8'd6, 8'd3, 8'd1},
            {8'h09, 8'h0A, 8'h0A, 8'h09, 8'h09, 8'h08}, 1'b0, 0, 3);
        run({8'd1, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd5, 8'd4, 8'd5, 8'd6, 8'd3, 8'd1},
            {8'h09, 8'h0A, 8'h0A, 8'h09, 8'h09, 8'h08}, 1'b0, 0, -1);

        chk("done_queue_empty", done_q.size() == 0, 64'(done_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
